led_pattern_scheduler: RTL

Shares the board's two status LEDs between several internal status sources, e.g. a heartbeat, CSI-2 lock and an error flag. Each source raises a level request with a 16-bit blink pattern. A fixed-priority scheduler grants one source at a time, enforces a minimum display time, and steps the granted pattern at a slow tick derived from the on-chip oscillator clock. The block sits between the status logic and the led1/led2 pads.

---
 rtl/led_sched_pkg.sv | 25 ++
 rtl/led_tick_prescaler.sv | 42 ++++
 rtl/led_pattern_scheduler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/led_sched_pkg.sv
// led_sched_pkg
// Shared types and helpers for the LED pattern scheduler.
//   state_e      : scheduler states (IDLE, SHOW)
//   LED_OFF      : pad level for an unlit, active-low LED
//   PAT_W        : width of one LED sequence inside a requester pattern
//   REQ_MAX_W    : widest request vector prio_onehot can handle
//   prio_onehot  : lowest set index of a request vector, as one-hot
package led_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  localparam logic LED_OFF   = 1'b1;
  localparam int   PAT_W     = 8;
  localparam int   REQ_MAX_W = 32;

  // Two's-complement trick: r & -r isolates the lowest set bit, which is
  // the highest-priority requester. Zero in gives zero out.
  function automatic logic [REQ_MAX_W-1:0] prio_onehot(input logic [REQ_MAX_W-1:0] r);
    return r & (~r + REQ_MAX_W'(1));
  endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// led_tick_prescaler
// Free-running divider that produces a one-cycle step pulse for slow
// indicators. The count runs 0..TICK_DIV-1 and wraps; tick is high in
// the cycle the count equals TICK_DIV-1.
// Ports:
//   clk_osc : oscillator clock
//   reset   : asynchronous, active-low reset
//   tick    : registered one-cycle pulse every TICK_DIV cycles
module led_tick_prescaler #(
  parameter int TICK_DIV = 1048576
) (
  input  logic clk_osc,
  input  logic reset,
  output logic tick
);

  localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    // Decode the next count so the pulse is a flop output yet still
    // coincides with the cycle in which the count sits at its last value.
    tick_d = (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk_osc or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/led_pattern_scheduler.sv
// led_pattern_scheduler
// Shares two active-low status LEDs between NUM_REQ sources. A fixed-
// priority scheduler (index 0 highest) grants one source, latches its
// 16-bit pattern and steps it one bit per prescaler tick, holding each
// grant for at least MIN_HOLD_TICKS ticks before preemption or release.
// Ports:
//   clk_osc : oscillator clock
//   reset   : asynchronous, active-low reset
//   req     : level request per source
//   pattern : 16 bits per source; [7:0] led1 sequence, [15:8] led2
//             sequence, bit 0 shown first, 1 = lit
//   grant   : one-hot current owner, zero when idle
//   busy    : high while a grant is active
//   tick    : pattern step pulse, for observability
//   led1    : pad drive, active-low
//   led2    : pad drive, active-low
module led_pattern_scheduler
  import led_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TICK_DIV       = 1048576,
  parameter int MIN_HOLD_TICKS = 8
) (
  input  logic                    clk_osc,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [16*NUM_REQ-1:0]   pattern,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    busy,
  output logic                    tick,
  output logic                    led1,
  output logic                    led2
);

  localparam logic [7:0] HOLD_MAX = 8'(MIN_HOLD_TICKS);

  logic                 tick_w;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic [2*PAT_W-1:0]   pat_q, pat_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           hold_q, hold_d;
  logic                 led1_q, led1_d;
  logic                 led2_q, led2_d;

  logic [2*PAT_W-1:0]   pat_arr [NUM_REQ];
  logic [NUM_REQ-1:0]   sel_onehot;
  logic [2*PAT_W-1:0]   sel_pat;
  logic [NUM_REQ-1:0]   higher_req;
  logic                 owner_req;
  logic [7:0]           hold_inc;
  logic                 hold_met;
  logic [2:0]           bit_next;
  logic [PAT_W-1:0]     led1_seq;
  logic [PAT_W-1:0]     led2_seq;

  led_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk_osc (clk_osc),
    .reset   (reset),
    .tick    (tick_w)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pat_split
    assign pat_arr[gi] = pattern[gi*2*PAT_W +: 2*PAT_W];
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    pat_d     = pat_q;
    bit_idx_d = bit_idx_q;
    hold_d    = hold_q;
    led1_d    = led1_q;
    led2_d    = led2_q;

    // Highest-priority requester among all current requests.
    sel_onehot = NUM_REQ'(prio_onehot(REQ_MAX_W'(req)));
    sel_pat    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_onehot[i]) sel_pat = sel_pat | pat_arr[i];
    end

    // Bits below the owner's index are the requesters that outrank it.
    higher_req = req & (grant_q - NUM_REQ'(1));
    owner_req  = |(req & grant_q);
    hold_inc   = (hold_q >= HOLD_MAX) ? HOLD_MAX : hold_q + 8'd1;
    hold_met   = (hold_inc >= HOLD_MAX);
    bit_next   = bit_idx_q + 3'd1;
    led1_seq   = pat_q[PAT_W-1:0];
    led2_seq   = pat_q[2*PAT_W-1:PAT_W];

    unique case (state_q)
      IDLE: begin
        led1_d = LED_OFF;
        led2_d = LED_OFF;
        if (|req) begin
          state_d   = SHOW;
          grant_d   = sel_onehot;
          busy_d    = 1'b1;
          pat_d     = sel_pat;
          bit_idx_d = '0;
          hold_d    = '0;
          led1_d    = ~sel_pat[0];
          led2_d    = ~sel_pat[PAT_W];
        end
      end
      SHOW: begin
        if (tick_w) begin
          if (hold_met && ((|higher_req) || (!owner_req && (|req)))) begin
            // Preemption and release collapse to "hand over to the
            // highest-priority requester still asking".
            grant_d   = sel_onehot;
            pat_d     = sel_pat;
            bit_idx_d = '0;
            hold_d    = '0;
            led1_d    = ~sel_pat[0];
            led2_d    = ~sel_pat[PAT_W];
          end else if (hold_met && !owner_req) begin
            state_d   = IDLE;
            grant_d   = '0;
            busy_d    = 1'b0;
            bit_idx_d = '0;
            hold_d    = '0;
            led1_d    = LED_OFF;
            led2_d    = LED_OFF;
          end else begin
            hold_d    = hold_inc;
            bit_idx_d = bit_next;
            led1_d    = ~led1_seq[bit_next];
            led2_d    = ~led2_seq[bit_next];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_osc or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      pat_q     <= '0;
      bit_idx_q <= '0;
      hold_q    <= '0;
      led1_q    <= LED_OFF;
      led2_q    <= LED_OFF;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      pat_q     <= pat_d;
      bit_idx_q <= bit_idx_d;
      hold_q    <= hold_d;
      led1_q    <= led1_d;
      led2_q    <= led2_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign tick  = tick_w;
  assign led1  = led1_q;
  assign led2  = led2_q;

endmodule
